mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline.
- Consumes the EX/MEM pipeline register outputs and drives a word-wide data-memory bus with a req/ready handshake.
- Stalls the front of the pipeline while an access is outstanding.
- Registers the write-back result (the MEM/WB register is internal) for the WB stage and forwarding.
- Flags misaligned and timed-out accesses as exceptions.

Parameters:
- TIMEOUT, 16, max cycles mem_req may remain un-acked before abort (≥2)
- CNT_W, 5, width of the wait counter (must hold TIMEOUT)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-low
- alu_out_in  in  32  EX/MEM ALU result / memory address
- rt_in  in  32  EX/MEM store data
- write_addr_in  in  5  destination register
- pc_next_in  in  32  PC+4 of the instruction
- MemRead_in  in  1  load
- MemWrite_in  in  1  store
- MemtoReg_in  in  2  WB select: 00 alu_out, 01 load data, 10 pc_next, 11 alu_out
- RegWrite_in  in  1  register write enable
- mem_req  out  1  bus request
- mem_we  out  1  write strobe
- mem_addr  out  32  word address (alu_out_in)
- mem_wdata  out  32  store data (rt_in)
- mem_rdata  in  32  load data, valid with mem_ready
- mem_ready  in  1  bus completes the access this cycle
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle
- wb_data  out  32  MEM/WB selected result
- wb_addr  out  5  MEM/WB destination register
- wb_RegWrite  out  1  MEM/WB write enable
- exc_valid  out  1  one-cycle exception pulse (registered)
- exc_cause  out  2  01 misaligned, 10 bus timeout
- exc_addr  out  32  faulting address

Behaviour:
- Reset (reset==0 at a clk edge):
  - wb_data, wb_addr, wb_RegWrite, exc_* are cleared to 0.
  - FSM goes to IDLE and the counter clears.
  - mem_req is 0 during the cycle that reset is low.
  - Reset mid-access abandons the transfer with no write-back.
- Definitions:
  - op = MemRead_in | MemWrite_in. If both are set, treat as a store.
  - mis = op & (alu_out_in[1:0] != 0).
- FSM states:
  - IDLE: no access outstanding.
  - WAIT: mem_req has been held for at least one cycle.
- mem_req:
  - Driven combinationally: mem_req = op & ~mis & reset.
  - mem_we = MemWrite_in & mem_req.
  - Bus fields are held stable while mem_req is high; they are guaranteed stable because EX/MEM is frozen by stall.
- Zero-wait access: if mem_ready=1 in the same cycle as mem_req, the access completes, stall=0 and the result is captured at that edge.
- Waiting:
  - stall = mem_req & ~mem_ready & ~tmo, where tmo = (state==WAIT) & (cnt==TIMEOUT-1).
  - IDLE→WAIT on mem_req & ~mem_ready; cnt←1.
  - In WAIT, cnt increments each cycle.
  - WAIT→IDLE on mem_ready or tmo.
- Timeout:
  - In the tmo cycle, stall=0 and mem_req is still high.
  - At the edge, the MEM/WB bubble is captured.
  - exc_valid=1 for one cycle with cause 10 and exc_addr=alu_out_in.
  - The bus must ignore a late ready.
- Misaligned: no request is issued, no stall, bubble is captured, exc_valid with cause 01 on the next cycle.
- MEM/WB capture at each edge where stall=0 and reset=1:
  - wb_addr←write_addr_in.
  - wb_RegWrite←RegWrite_in & ~fault.
  - wb_data selected by MemtoReg_in (01 uses mem_rdata).
- While stall=1: MEM/WB captures a bubble (wb_RegWrite←0, wb_addr←0, wb_data←0). The WB stage must not see the same instruction twice.
- Non-memory instructions: pass through with 1-cycle latency, no stall.
- Loads with mem_ready in cycle k: wb_data is valid in cycle k+1.
- A stall never lasts more than TIMEOUT-1 cycles.

Decomposition:
- Shared package pipe_pkg:
  - MemtoReg encodings (WB_ALU, WB_MEM, WB_PC).
  - exc_cause codes (EXC_NONE, EXC_ALIGN, EXC_BUSTO).
  - FSM state typedef.
- One sub-module, mem_wb_reg: the registered MEM/WB output with bubble insert and a synchronous active-low reset.
- The handshake FSM and counter stay in mem_access_stage.

Test Plan:
- ALU op, alu_out_in=0x1234, MemtoReg=00, RegWrite=1, wa=5 → next cycle wb_data=0x1234, wb_addr=5, wb_RegWrite=1, stall never high.
- Load addr 0x100 with mem_ready low for 3 cycles then high, rdata=0xDEADBEEF → stall high for exactly 3 cycles, wb_RegWrite=0 during those cycles, then wb_data=0xDEADBEEF for one cycle.
- Store addr 0x200, rt=0xA5A5A5A5, zero-wait ready → mem_req=mem_we=1 for one cycle, wdata=0xA5A5A5A5, no stall, wb_RegWrite=0.
- Load addr 0x102 → mem_req never asserted, exc_valid=1 for one cycle next cycle, exc_cause=01, exc_addr=0x102, wb_RegWrite=0.
- Load with ready held low, TIMEOUT=16 → stall high for 15 cycles, released in the 16th, exc_cause=10, bubble written back, FSM back to IDLE.
- jal-style MemtoReg=10, pc_next=0x40 → wb_data=0x40. Also assert reset=0 during a WAIT → all outputs 0 and mem_req=0 next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared definitions for the MIPS pipeline MEM stage:
//               write-back select encodings, exception cause codes, the
//               memory-handshake FSM state type and the WB result mux.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // MemtoReg encodings (2'b11 falls back to the ALU result)
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;

    // Exception cause codes
    localparam logic [1:0] EXC_NONE  = 2'b00;
    localparam logic [1:0] EXC_ALIGN = 2'b01;
    localparam logic [1:0] EXC_BUSTO = 2'b10;

    // Memory handshake FSM
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,   // no access outstanding
        ST_WAIT = 1'b1    // mem_req held for at least one cycle
    } mem_state_t;

    // Write-back result selection
    function automatic logic [31:0] wb_select(
        input logic [1:0]  sel,
        input logic [31:0] alu,
        input logic [31:0] rdata,
        input logic [31:0] pc_next
    );
        logic [31:0] res;
        case (sel)
            WB_MEM:  res = rdata;
            WB_PC:   res = pc_next;
            default: res = alu;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wb_reg.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_reg
// Description : MEM/WB pipeline register with bubble insertion.
//               A bubble clears the destination, data and write enable so
//               the WB stage never retires a stalled or faulting instruction.
// Ports       : clk, reset (sync, active-low)
//               i_bubble     - capture a bubble instead of the inputs
//               i_wb_data    - selected result
//               i_wb_addr    - destination register
//               i_reg_write  - register write enable
//               o_wb_data / o_wb_addr / o_reg_write - registered outputs
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_bubble,
    input  logic [31:0] i_wb_data,
    input  logic [4:0]  i_wb_addr,
    input  logic        i_reg_write,
    output logic [31:0] o_wb_data,
    output logic [4:0]  o_wb_addr,
    output logic        o_reg_write
);

    logic [31:0] r_wb_data;
    logic [4:0]  r_wb_addr;
    logic        r_reg_write;

    always_ff @(posedge clk) begin
        if (!reset || i_bubble) begin
            r_wb_data   <= 32'd0;
            r_wb_addr   <= 5'd0;
            r_reg_write <= 1'b0;
        end else begin
            r_wb_data   <= i_wb_data;
            r_wb_addr   <= i_wb_addr;
            r_reg_write <= i_reg_write;
        end
    end

    assign o_wb_data   = r_wb_data;
    assign o_wb_addr   = r_wb_addr;
    assign o_reg_write = r_reg_write;

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : MEM stage of the 5-stage MIPS pipeline. Drives a word-wide
//               data bus with a req/ready handshake, stalls the front of the
//               pipeline while an access is outstanding, registers the MEM/WB
//               result and flags misaligned / timed-out accesses.
// Ports       : clk, reset (sync, active-low)
//               EX/MEM inputs : alu_out_in, rt_in, write_addr_in, pc_next_in,
//                               MemRead_in, MemWrite_in, MemtoReg_in,
//                               RegWrite_in
//               Bus           : mem_req, mem_we, mem_addr, mem_wdata,
//                               mem_rdata, mem_ready
//               Pipeline      : stall
//               MEM/WB        : wb_data, wb_addr, wb_RegWrite
//               Exceptions    : exc_valid, exc_cause, exc_addr
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] alu_out_in,
    input  logic [31:0] rt_in,
    input  logic [4:0]  write_addr_in,
    input  logic [31:0] pc_next_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [1:0]  MemtoReg_in,
    input  logic        RegWrite_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        stall,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_addr,
    output logic        wb_RegWrite,
    output logic        exc_valid,
    output logic [1:0]  exc_cause,
    output logic [31:0] exc_addr
);

    import pipe_pkg::*;

    localparam logic [CNT_W-1:0] c_TMO_CNT = CNT_W'(TIMEOUT - 1);

    mem_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_exc_valid;
    logic [1:0]       r_exc_cause;
    logic [31:0]      r_exc_addr;

    logic        w_op;
    logic        w_mis;
    logic        w_tmo;
    logic        w_req;
    logic        w_stall;
    logic        w_fault;
    logic [31:0] w_wb_sel;

    // A simultaneous read+write is a store: mem_we follows MemWrite_in alone.
    assign w_op    = MemRead_in | MemWrite_in;
    assign w_mis   = w_op & (alu_out_in[1:0] != 2'b00);
    assign w_req   = w_op & ~w_mis & reset;
    assign w_tmo   = (r_state == ST_WAIT) && (r_cnt == c_TMO_CNT);
    // The timeout cycle releases the stall so the faulting access retires
    // as a bubble; mem_req stays high but any late ready is ignored.
    assign w_stall = w_req & ~mem_ready & ~w_tmo;
    assign w_fault = w_mis | w_tmo;

    assign mem_req   = w_req;
    assign mem_we    = MemWrite_in & w_req;
    assign mem_addr  = alu_out_in;
    assign mem_wdata = rt_in;
    assign stall     = w_stall;

    assign w_wb_sel = wb_select(MemtoReg_in, alu_out_in, mem_rdata, pc_next_in);

    // Handshake FSM and wait counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req && !mem_ready) begin
                        r_state <= ST_WAIT;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    // Dropping the request here means the upstream was
                    // flushed; return to idle rather than wait it out.
                    if (mem_ready || w_tmo || !w_req) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // One-cycle exception pulse, reported the cycle after the fault
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_exc_valid <= 1'b0;
            r_exc_cause <= EXC_NONE;
            r_exc_addr  <= 32'd0;
        end else if (w_fault) begin
            r_exc_valid <= 1'b1;
            r_exc_cause <= w_mis ? EXC_ALIGN : EXC_BUSTO;
            r_exc_addr  <= alu_out_in;
        end else begin
            r_exc_valid <= 1'b0;
            r_exc_cause <= EXC_NONE;
            r_exc_addr  <= 32'd0;
        end
    end

    assign exc_valid = r_exc_valid;
    assign exc_cause = r_exc_cause;
    assign exc_addr  = r_exc_addr;

    mem_wb_reg u_mem_wb_reg (
        .clk         (clk),
        .reset       (reset),
        .i_bubble    (w_stall | w_fault),
        .i_wb_data   (w_wb_sel),
        .i_wb_addr   (write_addr_in),
        .i_reg_write (RegWrite_in & ~w_fault),
        .o_wb_data   (wb_data),
        .o_wb_addr   (wb_addr),
        .o_reg_write (wb_RegWrite)
    );

endmodule
`default_nettype wire
